// File: rtl/spi_ram_pkg.sv
// Frame opcodes shared between the SPI slave and the command RAM stage.
package spi_ram_pkg;

  typedef enum logic [1:0] {
    CMD_WR_ADDR = 2'b00,
    CMD_WR_DATA = 2'b01,
    CMD_RD_ADDR = 2'b10,
    CMD_RD_DATA = 2'b11
  } cmd_e;

  localparam int unsigned FRAME_W = 10;
  localparam int unsigned DATA_W  = 8;

  function automatic cmd_e frame_cmd(input logic [FRAME_W-1:0] frame);
    return cmd_e'(frame[FRAME_W-1:FRAME_W-2]);
  endfunction

endpackage

// File: rtl/spi_cmd_ram_if.sv
// Frame/response bundle between the SPI slave (master side) and the command RAM (slave side).
interface spi_cmd_ram_if;
  import spi_ram_pkg::*;

  logic [FRAME_W-1:0] rx_data;
  logic               rx_valid;
  logic [DATA_W-1:0]  tx_data;
  logic               tx_valid;

  modport master (
    output rx_data,
    output rx_valid,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output tx_data,
    output tx_valid
  );

endinterface

// File: rtl/spi_ram_mem.sv
// Single-write, single synchronous-read byte array; the read register clears on reset,
// the array itself does not.
module spi_ram_mem #(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_wr_en,
  input  logic [ADDR_SIZE-1:0] i_wr_addr,
  input  logic [7:0]           i_wr_data,
  input  logic                 i_rd_en,
  input  logic [ADDR_SIZE-1:0] i_rd_addr,
  output logic [7:0]           o_rd_data
);

  logic [7:0] r_mem [MEM_DEPTH];
  logic [7:0] r_rd_data;

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_rd_data <= 8'h00;
    end else if (i_rd_en) begin
      r_rd_data <= r_mem[i_rd_addr];
    end
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/spi_cmd_ram.sv
// Decodes SPI command frames into address updates, memory writes and read responses.
module spi_cmd_ram
  import spi_ram_pkg::*;
#(
  parameter int unsigned MEM_DEPTH = 256,
  parameter int unsigned ADDR_SIZE = 8,
  parameter bit          AUTO_INC  = 1'b0
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  spi_cmd_ram_if.slave  bus
);

  logic [ADDR_SIZE-1:0] r_wr_addr;
  logic [ADDR_SIZE-1:0] r_rd_addr;
  logic                 r_tx_valid;
  cmd_e                 w_cmd;
  logic                 w_wr_en;
  logic                 w_rd_en;
  logic [ADDR_SIZE-1:0] w_addr_pl;
  logic [7:0]           w_rd_data;

  assign w_cmd     = frame_cmd(bus.rx_data);
  assign w_addr_pl = bus.rx_data[ADDR_SIZE-1:0];

  // Reset suppresses any command presented in the same cycle, including writes.
  always_comb begin
    w_wr_en = 1'b0;
    w_rd_en = 1'b0;
    if (i_rst_n && bus.rx_valid) begin
      w_wr_en = (w_cmd == CMD_WR_DATA);
      w_rd_en = (w_cmd == CMD_RD_DATA);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_wr_addr  <= '0;
      r_rd_addr  <= '0;
      r_tx_valid <= 1'b0;
    end else begin
      r_tx_valid <= w_rd_en;
      if (bus.rx_valid) begin
        unique case (w_cmd)
          CMD_WR_ADDR: r_wr_addr <= w_addr_pl;
          CMD_WR_DATA: if (AUTO_INC) r_wr_addr <= r_wr_addr + ADDR_SIZE'(1);
          CMD_RD_ADDR: r_rd_addr <= w_addr_pl;
          CMD_RD_DATA: if (AUTO_INC) r_rd_addr <= r_rd_addr + ADDR_SIZE'(1);
        endcase
      end
    end
  end

  spi_ram_mem #(
    .MEM_DEPTH (MEM_DEPTH),
    .ADDR_SIZE (ADDR_SIZE)
  ) u_mem (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_wr_en   (w_wr_en),
    .i_wr_addr (r_wr_addr),
    .i_wr_data (bus.rx_data[7:0]),
    .i_rd_en   (w_rd_en),
    .i_rd_addr (r_rd_addr),
    .o_rd_data (w_rd_data)
  );

  assign bus.tx_data  = w_rd_data;
  assign bus.tx_valid = r_tx_valid;

endmodule

// File: tb/tb_spi_cmd_ram.sv
// Drives one stimulus stream into a non-incrementing and an auto-incrementing instance
// and checks both against a reference model of the command set.
module tb_spi_cmd_ram;

  logic       clk;
  logic       rst_n;
  logic [9:0] rx_data;
  logic       rx_valid;

  int n_checks = 0;
  int n_fail   = 0;

  spi_cmd_ram_if if0 ();
  spi_cmd_ram_if if1 ();

  assign if0.rx_data  = rx_data;
  assign if0.rx_valid = rx_valid;
  assign if1.rx_data  = rx_data;
  assign if1.rx_valid = rx_valid;

  spi_cmd_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b0)) u_dut0 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if0)
  );

  spi_cmd_ram #(.MEM_DEPTH(256), .ADDR_SIZE(8), .AUTO_INC(1'b1)) u_dut1 (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] dut_data [2];
  logic       dut_valid [2];
  assign dut_data[0]  = if0.tx_data;
  assign dut_data[1]  = if1.tx_data;
  assign dut_valid[0] = if0.tx_valid;
  assign dut_valid[1] = if1.tx_valid;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h, expected %02h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: index 0 has no auto-increment, index 1 post-increments mod 256.
  logic [7:0]  m_mem    [2][256];
  bit          m_known  [2][256];
  int unsigned m_wa     [2];
  int unsigned m_ra     [2];
  logic [7:0]  m_txd    [2];
  bit          m_txd_ok [2];
  bit          m_txv    [2];
  bit          m_live = 1'b0;

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        m_wa[k] = 0; m_ra[k] = 0;
        m_txd[k] = 8'h00; m_txd_ok[k] = 1'b1; m_txv[k] = 1'b0;
      end else begin
        m_txv[k] = 1'b0;
        if (rx_valid) begin
          case (rx_data[9:8])
            2'd0: m_wa[k] = int'(rx_data[7:0]);
            2'd1: begin
              m_mem[k][m_wa[k]]   = rx_data[7:0];
              m_known[k][m_wa[k]] = 1'b1;
              if (k == 1) m_wa[k] = (m_wa[k] + 1) % 256;
            end
            2'd2: m_ra[k] = int'(rx_data[7:0]);
            default: begin
              m_txd[k]    = m_mem[k][m_ra[k]];
              m_txd_ok[k] = m_known[k][m_ra[k]];
              m_txv[k]    = 1'b1;
              if (k == 1) m_ra[k] = (m_ra[k] + 1) % 256;
            end
          endcase
        end
      end
    end
    if (!rst_n) m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("model_tx_valid[%0d]", k), {7'd0, dut_valid[k]}, {7'd0, m_txv[k]});
        if (m_txd_ok[k]) chk($sformatf("model_tx_data[%0d]", k), dut_data[k], m_txd[k]);
      end
    end
  end

  task automatic send(input logic [1:0] op, input logic [7:0] pl);
    rx_valid = 1'b1;
    rx_data  = {op, pl};
    @(posedge clk);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic idle();
    rx_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 10'd0;
    repeat (2) @(negedge clk);
    chk("reset_tx_valid0", {7'd0, if0.tx_valid}, 8'h00);
    chk("reset_tx_data0", if0.tx_data, 8'h00);
    chk("reset_tx_valid1", {7'd0, if1.tx_valid}, 8'h00);
    chk("reset_wr_addr0", u_dut0.r_wr_addr, 8'h00);
    chk("reset_rd_addr0", u_dut0.r_rd_addr, 8'h00);
    chk("reset_rd_addr1", u_dut1.r_rd_addr, 8'h00);
    rst_n = 1'b1;

    // Seed address 0 so a post-reset read has a distinctive value.
    send(2'b00, 8'h00);
    send(2'b01, 8'h3C);

    // Write then read back.
    send(2'b00, 8'h12);
    send(2'b01, 8'hA5);
    send(2'b10, 8'h12);
    send(2'b11, 8'h5A);
    chk("wr_rd_data0", if0.tx_data, 8'hA5);
    chk("wr_rd_valid0", {7'd0, if0.tx_valid}, 8'h01);
    chk("wr_rd_data1", if1.tx_data, 8'hA5);
    idle();
    chk("pulse_drop0", {7'd0, if0.tx_valid}, 8'h00);

    // Back-to-back reads without increment.
    send(2'b10, 8'h12);
    for (int i = 0; i < 3; i++) begin
      send(2'b11, 8'h00);
      chk($sformatf("b2b_data0_%0d", i), if0.tx_data, 8'hA5);
      chk($sformatf("b2b_valid0_%0d", i), {7'd0, if0.tx_valid}, 8'h01);
    end
    idle();
    chk("b2b_idle_valid0", {7'd0, if0.tx_valid}, 8'h00);
    chk("b2b_hold_data0", if0.tx_data, 8'hA5);

    // Reset mid-use, with a read presented during reset that must be ignored.
    rst_n = 1'b0;
    send(2'b11, 8'h00);
    chk("rst_mid_valid0", {7'd0, if0.tx_valid}, 8'h00);
    chk("rst_mid_data1", if1.tx_data, 8'h00);
    rst_n = 1'b1;
    send(2'b11, 8'hEE);
    chk("rst_addr0_data0", if0.tx_data, 8'h3C);
    chk("rst_addr0_data1", if1.tx_data, 8'h3C);
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    chk("rst_keep_data0", if0.tx_data, 8'hA5);

    // Auto-increment wraps from 0xFF to 0x00.
    send(2'b00, 8'hFF);
    send(2'b01, 8'h11);
    send(2'b01, 8'h22);
    send(2'b10, 8'hFF);
    send(2'b11, 8'h00);
    chk("wrap_rd1_a", if1.tx_data, 8'h11);
    chk("wrap_rd0_a", if0.tx_data, 8'h22);
    send(2'b11, 8'h00);
    chk("wrap_rd1_b", if1.tx_data, 8'h22);
    chk("wrap_rd0_b", if0.tx_data, 8'h22);

    // Idle traffic with random frames must have no effect.
    for (int i = 0; i < 100; i++) begin
      rx_data = 10'($urandom);
      idle();
    end
    send(2'b10, 8'h12);
    send(2'b11, 8'h00);
    chk("idle_keep_data0", if0.tx_data, 8'hA5);
    chk("idle_keep_data1", if1.tx_data, 8'hA5);
    send(2'b10, 8'h00);
    send(2'b11, 8'h00);
    chk("idle_addr0_data0", if0.tx_data, 8'h3C);
    chk("idle_addr0_data1", if1.tx_data, 8'h22);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
